i2c_master_read_byte: RTL and testbench
=======================================

# i2c_master_read_byte

Byte-level read sequencer for the I2C master.
- Sits directly above the bit-level reader (`I2C_master_read_bit`) and the bit-level writer (`I2C_master_write_bit`), and drives each through its go/finish handshake.
- Reads 8 bits MSB-first, then writes the ACK/NACK bit, then returns the assembled byte to the transaction controller with one finish pulse.
- Owns no SCL/SDA pins; all bus activity is delegated to the bit modules.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clock`  input  1  system clock; all state changes on its rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `go`  input  1  start request; held high by the caller until `finish`
- `ack`  input  1  sampled with `go`: 1 = send ACK (SDA low), 0 = send NACK (SDA high)
- `finish`  output  1  one-cycle completion pulse
- `data`  output  8  last successfully received byte
- `error`  output  1  one-cycle pulse coincident with `finish` when aborted
- `bit_read_go`  output  1  go to bit reader
- `bit_read_finish`  input  1  finish pulse from bit reader
- `bit_read_data`  input  1  sampled bit, valid when `bit_read_finish`=1
- `bit_read_error`  input  1  bit reader error, valid with `bit_read_finish`
- `bit_write_go`  output  1  go to bit writer
- `bit_write_data`  output  1  bit to write (ACK/NACK)
- `bit_write_finish`  input  1  finish pulse from bit writer
- `bit_write_error`  input  1  bit writer error, valid with `bit_write_finish`

## Operation
States: `IDLE`, `READ`, `READ_GAP`, `ACK`, `DONE`, `RELEASE`.

- **IDLE**
  - `go`=1 → latch `ack`.
  - Clear 3-bit counter `cnt` and shift register `sreg`.
  - Go to `READ`.
- **READ**
  - `bit_read_go`=1.
  - On `bit_read_finish`=1 with `bit_read_error`=1 → `DONE` with error.
  - On `bit_read_finish`=1 without error:
    - `sreg <= {sreg[6:0], bit_read_data}`.
    - `cnt==7` → `ACK`; otherwise `cnt <= cnt+1` and go to `READ_GAP`.
- **READ_GAP**
  - `bit_read_go`=0 for exactly one cycle, then `READ`.
  - The gap guarantees the bit module sees go low between bits.
- **ACK**
  - `bit_write_go`=1.
  - `bit_write_data` = `~ack_latched`.
  - On `bit_write_finish`=1 → `DONE`. Error flag = `bit_write_error`.
- **DONE**
  - `finish`=1 for one cycle; `error`=1 if aborted.
  - On success, `data <= sreg`. On error, `data` is unchanged.
  - Always go to `RELEASE`.
- **RELEASE**
  - Wait for `go`=0, then `IDLE`.
  - Prevents retrigger while the caller still holds `go`.

Rules:
- `go` falling during `READ`/`READ_GAP`/`ACK` is ignored; the byte runs to completion.
- `ack` is sampled only in `IDLE`; later changes are ignored.
- A finish from a bit module whose go is not asserted is ignored.
- Error abort stops immediately; no further bits are read and no ACK is written.

## Timing
- Reset (async, immediate):
  - state=`IDLE`, `finish`=0, `error`=0, `data`=8'h00.
  - `bit_read_go`=0, `bit_write_go`=0, `bit_write_data`=1, `cnt`=0, `sreg`=0.
- All outputs are registered.
- `bit_read_go` rises 1 cycle after `go` is sampled in `IDLE`.
- Each bit costs (bit-module latency + 1 finish cycle + 1 gap cycle).
- `bit_read_go` falls the cycle after `bit_read_finish`.
- `bit_write_go` rises the cycle after the 8th `bit_read_finish`; there is no gap before ACK because it is a different module.
- `finish` rises the cycle after `bit_write_finish`, or the cycle after the erroring finish.
- `data` updates in the same cycle `finish` rises.
- Reset mid-byte: go outputs drop asynchronously and the partial byte is discarded; `data` is reset to 8'h00.

## Structure
- Shared package `i2c_pkg`:
  - state encoding (3-bit localparams)
  - `I2C_ACK`=1'b0, `I2C_NACK`=1'b1
  - `I2C_BYTE_BITS`=8
- Natural sub-module: `i2c_byte_shift`, the 8-bit shift register plus 3-bit bit counter.
  - inputs: `clear`, `shift_en`, `bit_in`
  - outputs: `byte_out`, `last`
  - reused later by the byte writer.
- The FSM stays in this module.

## Test plan
The bench uses a behavioural bit-reader/bit-writer model with programmable latency (default 10 cycles) and a per-bit error injection.

1. Model returns bits 1,0,1,0,0,1,0,1 with `ack`=1 → `data`=8'hA5, `bit_write_data`=0, one `finish` pulse, `error`=0.
2. Bits all 1 with `ack`=0 → `data`=8'hFF, `bit_write_data`=1 (NACK), `error`=0.
3. Error injected on the 4th read bit, with previous `data`=8'hA5 → `finish`+`error` pulse, exactly 4 `bit_read_go` assertions, no `bit_write_go`, `data` stays 8'hA5.
4. Caller holds `go` high 50 cycles past `finish` → no second `bit_read_go` until `go` drops; then a new `go` reads the next byte (8'h3C) correctly.
5. `reset_n` pulsed low during bit 5 → `bit_read_go`=0 immediately, `data`=8'h00, `finish` never asserted; the next `go` completes a full byte.
6. Every bit: `bit_read_go` is low for exactly one cycle between consecutive read requests, and 8 read handshakes occur before the single write handshake.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C master byte-level sequencers.
package i2c_pkg;

    localparam int I2C_BYTE_BITS = 8;

    // Level driven on SDA during the acknowledge bit.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // 3-bit state codes for the byte read sequencer.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READ     = 3'd1;
    localparam logic [2:0] ST_READ_GAP = 3'd2;
    localparam logic [2:0] ST_ACK      = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_RELEASE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_READ     = ST_READ,
        S_READ_GAP = ST_READ_GAP,
        S_ACK      = ST_ACK,
        S_DONE     = ST_DONE,
        S_RELEASE  = ST_RELEASE
    } rd_state_e;

endpackage

// File: rtl/i2c_byte_shift.sv
// 8-bit MSB-first shift register with a 3-bit bit counter.
// 'last' flags that the current shift completes the byte.
module i2c_byte_shift
    import i2c_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic [7:0] byte_out,
    output logic       last
);

    logic [2:0] cnt_q;
    logic [7:0] sreg_q;

    // Clear has priority; each shift appends the new bit at the LSB end.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= 3'd0;
            sreg_q <= 8'h00;
        end else if (clear) begin
            cnt_q  <= 3'd0;
            sreg_q <= 8'h00;
        end else if (shift_en) begin
            cnt_q  <= cnt_q + 3'd1;
            sreg_q <= {sreg_q[6:0], bit_in};
        end
    end

    assign byte_out = sreg_q;
    assign last     = (cnt_q == 3'(I2C_BYTE_BITS - 1));

endmodule

// File: rtl/i2c_master_read_byte.sv
// Byte-level read sequencer: issues eight bit reads, then one ACK/NACK
// bit write, and reports the assembled byte with a single finish pulse.
module i2c_master_read_byte
    import i2c_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic       ack,
    output logic       finish,
    output logic [7:0] data,
    output logic       error,
    output logic       bit_read_go,
    input  logic       bit_read_finish,
    input  logic       bit_read_data,
    input  logic       bit_read_error,
    output logic       bit_write_go,
    output logic       bit_write_data,
    input  logic       bit_write_finish,
    input  logic       bit_write_error
);

    rd_state_e  state_q, state_d;
    logic       ack_q, ack_d;
    logic       finish_q, finish_d;
    logic       error_q, error_d;
    logic [7:0] data_q, data_d;
    logic       rgo_q, rgo_d;
    logic       wgo_q, wgo_d;
    logic       wdata_q, wdata_d;

    logic       sh_clear;
    logic       sh_shift;
    logic [7:0] sh_byte;
    logic       sh_last;

    i2c_byte_shift u_shift (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (sh_clear),
        .shift_en (sh_shift),
        .bit_in   (bit_read_data),
        .byte_out (sh_byte),
        .last     (sh_last)
    );

    // State and registered outputs; reset drops both go lines immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            finish_q <= 1'b0;
            error_q  <= 1'b0;
            data_q   <= 8'h00;
            rgo_q    <= 1'b0;
            wgo_q    <= 1'b0;
            wdata_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            finish_q <= finish_d;
            error_q  <= error_d;
            data_q   <= data_d;
            rgo_q    <= rgo_d;
            wgo_q    <= wgo_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state logic; output registers are loaded on the transition so
    // they line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        finish_d = 1'b0;
        error_d  = 1'b0;
        data_d   = data_q;
        rgo_d    = rgo_q;
        wgo_d    = wgo_q;
        wdata_d  = wdata_q;
        sh_clear = 1'b0;
        sh_shift = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    ack_d    = ack;
                    sh_clear = 1'b1;
                    rgo_d    = 1'b1;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                // Finishes are only honoured while our read request is up.
                if (rgo_q && bit_read_finish) begin
                    rgo_d = 1'b0;
                    if (bit_read_error) begin
                        finish_d = 1'b1;
                        error_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        sh_shift = 1'b1;
                        if (sh_last) begin
                            wgo_d   = 1'b1;
                            wdata_d = ack_q ? I2C_ACK : I2C_NACK;
                            state_d = S_ACK;
                        end else begin
                            state_d = S_READ_GAP;
                        end
                    end
                end
            end
            S_READ_GAP: begin
                // One idle cycle so the bit reader sees go low between bits.
                rgo_d   = 1'b1;
                state_d = S_READ;
            end
            S_ACK: begin
                if (wgo_q && bit_write_finish) begin
                    wgo_d    = 1'b0;
                    finish_d = 1'b1;
                    error_d  = bit_write_error;
                    if (!bit_write_error) begin
                        data_d = sh_byte;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Caller must drop go before another byte can start.
                if (!go) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign finish         = finish_q;
    assign error          = error_q;
    assign data           = data_q;
    assign bit_read_go    = rgo_q;
    assign bit_write_go   = wgo_q;
    assign bit_write_data = wdata_q;

endmodule

// File: tb/tb_i2c_master_read_byte.sv
// Bench for i2c_master_read_byte: behavioural bit reader/writer with
// fixed latency and per-bit error injection, table-driven byte vectors
// plus a hand-written mid-byte reset sequence.
module tb_i2c_master_read_byte;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       go;
    logic       ack;
    logic       finish;
    logic [7:0] data;
    logic       error;
    logic       bit_read_go;
    logic       bit_read_finish;
    logic       bit_read_data;
    logic       bit_read_error;
    logic       bit_write_go;
    logic       bit_write_data;
    logic       bit_write_finish;
    logic       bit_write_error;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    i2c_master_read_byte dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .go               (go),
        .ack              (ack),
        .finish           (finish),
        .data             (data),
        .error            (error),
        .bit_read_go      (bit_read_go),
        .bit_read_finish  (bit_read_finish),
        .bit_read_data    (bit_read_data),
        .bit_read_error   (bit_read_error),
        .bit_write_go     (bit_write_go),
        .bit_write_data   (bit_write_data),
        .bit_write_finish (bit_write_finish),
        .bit_write_error  (bit_write_error)
    );

    // ---------------- behavioural bit modules ----------------
    int         latency = 10;
    logic [7:0] m_bits;
    int         m_err_idx;
    logic       m_wr_err;
    int         m_idx;
    int         rd_cyc, wr_cyc;
    logic       rd_armed, wr_armed;
    int         rd_hs, wr_hs;
    int         wr_reads_before;
    logic       wr_seen_data;

    initial begin
        bit_read_finish  = 1'b0;
        bit_read_data    = 1'b0;
        bit_read_error   = 1'b0;
        bit_write_finish = 1'b0;
        bit_write_error  = 1'b0;
        rd_armed = 1'b1; wr_armed = 1'b1;
        rd_cyc = 0; wr_cyc = 0;
        m_bits = 8'h00; m_err_idx = -1; m_wr_err = 1'b0; m_idx = 0;
        rd_hs = 0; wr_hs = 0; wr_reads_before = -1; wr_seen_data = 1'b0;
    end

    // Each bit module answers 'latency' cycles after its go rises and then
    // needs to see go low before it accepts another request.
    always @(negedge clock) begin
        bit_read_finish  = 1'b0;
        bit_read_error   = 1'b0;
        bit_write_finish = 1'b0;
        bit_write_error  = 1'b0;
        if (!bit_read_go) begin
            rd_armed = 1'b1;
            rd_cyc   = 0;
        end else if (rd_armed) begin
            rd_cyc++;
            if (rd_cyc >= latency) begin
                bit_read_finish = 1'b1;
                bit_read_data   = (m_idx < 8) ? m_bits[7 - m_idx] : 1'b0;
                bit_read_error  = (m_idx == m_err_idx);
                m_idx++;
                rd_hs++;
                rd_armed = 1'b0;
            end
        end
        if (!bit_write_go) begin
            wr_armed = 1'b1;
            wr_cyc   = 0;
        end else if (wr_armed) begin
            wr_cyc++;
            if (wr_cyc >= latency) begin
                bit_write_finish = 1'b1;
                bit_write_error  = m_wr_err;
                wr_seen_data     = bit_write_data;
                wr_reads_before  = rd_hs;
                wr_hs++;
                wr_armed = 1'b0;
            end
        end
    end

    // ---------------- output monitor ----------------
    int   rd_rises, wr_rises, fin_pulses, err_pulses, gap_bad;
    int   low_run, rises_in_byte;
    logic prev_rgo, prev_wgo;

    initial begin
        rd_rises = 0; wr_rises = 0; fin_pulses = 0; err_pulses = 0; gap_bad = 0;
        low_run = 0; rises_in_byte = 0; prev_rgo = 1'b0; prev_wgo = 1'b0;
    end

    always @(negedge clock) begin
        if (bit_read_go === 1'b1 && prev_rgo !== 1'b1) begin
            rd_rises++;
            if (rises_in_byte > 0 && low_run != 1) gap_bad++;
            rises_in_byte++;
        end
        if (bit_read_go === 1'b1) low_run = 0;
        else low_run++;
        if (bit_write_go === 1'b1 && prev_wgo !== 1'b1) wr_rises++;
        if (finish === 1'b1) begin
            fin_pulses++;
            rises_in_byte = 0;
        end
        if (error === 1'b1) err_pulses++;
        prev_rgo = bit_read_go;
        prev_wgo = bit_write_go;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counters();
        rd_rises = 0; wr_rises = 0; fin_pulses = 0; err_pulses = 0; gap_bad = 0;
        rises_in_byte = 0; rd_hs = 0; wr_hs = 0; wr_reads_before = -1;
    endtask

    typedef struct {
        logic [7:0] bits;
        logic       ack;
        int         err_idx;
        logic       wr_err;
        int         hold;
        logic [7:0] exp_data;
        logic       exp_bwd;
        logic       exp_err;
        int         exp_reads;
        int         exp_writes;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int n, input vec_t v);
        int cyc;
        logic [7:0] fdata;
        logic       ferr;
        m_bits = v.bits; m_err_idx = v.err_idx; m_wr_err = v.wr_err; m_idx = 0;
        clear_counters();
        ack = v.ack;
        go  = 1'b1;
        tick(); tick(); tick();
        ack = ~v.ack;   // must be ignored after the IDLE sample
        go  = 1'b1;
        cyc = 0;
        while (finish !== 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk($sformatf("v%0d finish_seen", n), finish, 1);
        fdata = data;
        ferr  = error;
        chk($sformatf("v%0d data_at_finish", n), fdata, v.exp_data);
        chk($sformatf("v%0d error_at_finish", n), ferr, v.exp_err);
        for (int i = 0; i < v.hold; i++) tick();
        go = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk($sformatf("v%0d read_go_count", n), rd_rises, v.exp_reads);
        chk($sformatf("v%0d write_go_count", n), wr_rises, v.exp_writes);
        chk($sformatf("v%0d finish_pulses", n), fin_pulses, 1);
        chk($sformatf("v%0d error_pulses", n), err_pulses, v.exp_err ? 1 : 0);
        chk($sformatf("v%0d read_gaps", n), gap_bad, 0);
        chk($sformatf("v%0d data_hold", n), data, v.exp_data);
        if (v.exp_writes > 0) begin
            chk($sformatf("v%0d ack_bit", n), wr_seen_data, v.exp_bwd);
            chk($sformatf("v%0d reads_before_write", n), wr_reads_before, 8);
        end
        $display("vec %0d: bits=%02h ack=%0b data=%02h error=%0b reads=%0d writes=%0d",
                 n, v.bits, v.ack, fdata, ferr, rd_rises, wr_rises);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        vecs[0] = '{8'hA5, 1'b1, -1, 1'b0,  0, 8'hA5, 1'b0, 1'b0, 8, 1};
        vecs[1] = '{8'hFF, 1'b0, -1, 1'b0,  0, 8'hFF, 1'b1, 1'b0, 8, 1};
        vecs[2] = '{8'hA5, 1'b1, -1, 1'b0,  0, 8'hA5, 1'b0, 1'b0, 8, 1};
        vecs[3] = '{8'h0F, 1'b1,  3, 1'b0,  0, 8'hA5, 1'b0, 1'b1, 4, 0};
        vecs[4] = '{8'h96, 1'b1, -1, 1'b0, 50, 8'h96, 1'b0, 1'b0, 8, 1};
        vecs[5] = '{8'h3C, 1'b0, -1, 1'b0,  0, 8'h3C, 1'b1, 1'b0, 8, 1};
        vecs[6] = '{8'h81, 1'b1, -1, 1'b1,  0, 8'h3C, 1'b0, 1'b1, 8, 1};

        go = 1'b0;
        ack = 1'b0;
        reset_n = 1'b0;
        tick(); tick();
        chk("rst finish", finish, 0);
        chk("rst error", error, 0);
        chk("rst data", data, 8'h00);
        chk("rst read_go", bit_read_go, 0);
        chk("rst write_go", bit_write_go, 0);
        chk("rst write_data", bit_write_data, 1);
        $display("reset: finish=%0b error=%0b data=%02h rgo=%0b wgo=%0b wdata=%0b",
                 finish, error, data, bit_read_go, bit_write_go, bit_write_data);
        reset_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset pulsed while the fifth bit is in flight.
        m_bits = 8'hF0; m_err_idx = -1; m_wr_err = 1'b0; m_idx = 0;
        clear_counters();
        ack = 1'b1;
        go  = 1'b1;
        cyc = 0;
        while (!(rd_hs == 4 && bit_read_go === 1'b1) && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("mid_rst reached_bit5", rd_hs, 4);
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst read_go", bit_read_go, 0);
        chk("mid_rst data", data, 8'h00);
        chk("mid_rst finish", finish, 0);
        go = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_rst no_finish", fin_pulses, 0);
        chk("mid_rst no_write", wr_rises, 0);
        $display("mid-byte reset: data=%02h finish_pulses=%0d write_go=%0d",
                 data, fin_pulses, wr_rises);

        begin
            vec_t v;
            v = '{8'hC3, 1'b1, -1, 1'b0, 0, 8'hC3, 1'b0, 1'b0, 8, 1};
            run_vec(7, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
